// File: rtl/tt_um_devinatkin_cookiemonster_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tt_um_devinatkin_cookiemonster_pkg
// Shared widths, game constants, 7-segment patterns and cost helper.
// Rev 1.0
// ---------------------------------------------------------------------------
package tt_um_devinatkin_cookiemonster_pkg;

  localparam int COUNT_W   = 16;
  localparam int LEVEL_W   = 3;
  localparam int MAX_LEVEL = 7;
  localparam int COST_STEP = 16;

  typedef logic [COUNT_W-1:0] count_t;
  typedef logic [LEVEL_W-1:0] level_t;

  // Hex glyphs, segment order gfedcba, active-high.
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  // Price of the next auto-clicker: 16 * (level + 1).
  function automatic count_t upgrade_cost(level_t lvl);
    return count_t'((32'(lvl) + 32'd1) * 32'(COST_STEP));
  endfunction

endpackage
`default_nettype wire

// File: rtl/tt_um_devinatkin_cookiemonster_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tt_um_devinatkin_cookiemonster_if
// Tiny Tapeout user-project pin bundle (everything except clk / rst_n).
// Rev 1.0
// ---------------------------------------------------------------------------
interface tt_um_devinatkin_cookiemonster_if;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  // Board / harness side: drives the inputs, watches the outputs.
  modport master (output ena, ui_in, uio_in, input uo_out, uio_out, uio_oe);
  // Game side.
  modport slave  (input ena, ui_in, uio_in, output uo_out, uio_out, uio_oe);
endinterface
`default_nettype wire

// File: rtl/tt_um_devinatkin_cookiemonster_button_debounce.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tt_um_devinatkin_cookiemonster_button_debounce
// 2-FF synchronizer, stability counter and rising-edge pulse for one button.
// Rev 1.0
// ---------------------------------------------------------------------------
module tt_um_devinatkin_cookiemonster_button_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic pulse
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic             stable;
  logic             stable_d;
  logic [CNT_W-1:0] cnt;

  // Bring the asynchronous button into the clock domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
    end
  end

  // Accept a new level only after it has disagreed for DEBOUNCE_CYCLES clocks in a row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable <= 1'b0;
      cnt    <= '0;
    end else if (sync2 == stable) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      stable <= sync2;
      cnt    <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Delayed copy of the debounced level for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stable_d <= 1'b0;
    else        stable_d <= stable;
  end

  assign pulse = stable & ~stable_d;

endmodule
`default_nettype wire

// File: rtl/tt_um_devinatkin_cookiemonster.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tt_um_devinatkin_cookiemonster
// Cookie clicker: click / buy buttons, auto-production tick, 4-digit hex display.
// Rev 1.0
// ---------------------------------------------------------------------------
module tt_um_devinatkin_cookiemonster
  import tt_um_devinatkin_cookiemonster_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int TICK_CYCLES     = 50000000,
  parameter int MUX_CYCLES      = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int TICK_W = $clog2(TICK_CYCLES + 1);
  localparam int MUX_W  = $clog2(MUX_CYCLES + 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYCLES - 1);
  localparam logic [MUX_W-1:0]  MUX_LAST  = MUX_W'(MUX_CYCLES - 1);
  localparam level_t            LEVEL_TOP = level_t'(MAX_LEVEL);

  logic              click_pulse;
  logic              buy_pulse;
  logic              sel_sync1;
  logic              sel;
  logic [TICK_W-1:0] tick_cnt;
  logic              tick_wrap;
  logic [MUX_W-1:0]  mux_cnt;
  logic [1:0]        digit;
  count_t            count;
  level_t            level;
  count_t            cost;
  logic              affordable;
  logic              buy_ok;
  logic [16:0]       sum;
  count_t            saturated;
  count_t            shown;
  logic [3:0]        nibble;
  logic              unused_inputs;

  assign unused_inputs = &{1'b0, uio_in, ui_in[6:2]};
  assign uio_oe        = 8'hFF;

  tt_um_devinatkin_cookiemonster_button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_click (
    .clk(clk), .rst_n(rst_n), .btn(ui_in[0]), .pulse(click_pulse)
  );

  tt_um_devinatkin_cookiemonster_button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_buy (
    .clk(clk), .rst_n(rst_n), .btn(ui_in[1]), .pulse(buy_pulse)
  );

  // Display select only needs synchronizing; bounce there is harmless.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_sync1 <= 1'b0;
      sel       <= 1'b0;
    end else begin
      sel_sync1 <= ui_in[7];
      sel       <= sel_sync1;
    end
  end

  // Auto-production period; frozen while the design is disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                tick_cnt <= '0;
    else if (ena && tick_wrap) tick_cnt <= '0;
    else if (ena)              tick_cnt <= tick_cnt + 1'b1;
  end

  assign tick_wrap  = ena && (tick_cnt == TICK_LAST);
  assign cost       = upgrade_cost(level);
  assign affordable = (count >= cost) && (level < LEVEL_TOP);
  assign buy_ok     = ena && buy_pulse && affordable;

  // Additions saturate first; an accepted buy then subtracts from that result.
  // The subtraction cannot underflow because saturated >= count >= cost.
  assign sum       = {1'b0, count} + {16'b0, ena & click_pulse} + (tick_wrap ? {14'b0, level} : 17'd0);
  assign saturated = sum[16] ? 16'hFFFF : sum[15:0];

  // Game state: cookie count and upgrade level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      level <= '0;
    end else begin
      count <= buy_ok ? (saturated - cost) : saturated;
      if (buy_ok) level <= level + 1'b1;
    end
  end

  // Digit scan keeps running regardless of ena.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mux_cnt <= '0;
      digit   <= 2'd0;
    end else if (mux_cnt == MUX_LAST) begin
      mux_cnt <= '0;
      digit   <= digit + 2'd1;
    end else begin
      mux_cnt <= mux_cnt + 1'b1;
    end
  end

  assign shown  = sel ? {4'h0, cost[11:0]} : count;
  assign nibble = 4'(shown >> {digit, 2'b00});

  // Registered pin drive; reflects digit/value one clock after they change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      uo_out  <= 8'h00;
      uio_out <= 8'h00;
    end else begin
      uo_out  <= {(digit == 2'd0) && (level != '0), SEG_TABLE[nibble]};
      uio_out <= {affordable, level, 4'b0001 << digit};
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tt_um_devinatkin_cookiemonster.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_tt_um_devinatkin_cookiemonster
// Randomized self-checking bench against a game-rule reference model.
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_tt_um_devinatkin_cookiemonster;

  localparam int DEB  = 4;
  localparam int TICK = 100;
  localparam int MUX  = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  tt_um_devinatkin_cookiemonster_if pins ();

  tt_um_devinatkin_cookiemonster #(
    .DEBOUNCE_CYCLES(DEB), .TICK_CYCLES(TICK), .MUX_CYCLES(MUX)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ena(pins.ena), .ui_in(pins.ui_in), .uio_in(pins.uio_in),
    .uo_out(pins.uo_out), .uio_out(pins.uio_out), .uio_oe(pins.uio_oe)
  );

  always #5 clk = ~clk;

  int          tests_run = 0;
  int          fails = 0;
  int          en_edges = 0;
  logic [15:0] m_count = 16'h0;
  int          m_level = 0;
  logic [6:0]  seg_ref [16];
  logic [6:0]  seen_seg [4];

  function automatic logic [15:0] sat_add(logic [15:0] a, int b);
    int s;
    s = int'(a) + b;
    return (s > 65535) ? 16'hFFFF : 16'(s);
  endfunction

  function automatic int cost_of(int lvl);
    return 16 * (lvl + 1);
  endfunction

  function automatic logic afford_of(logic [15:0] c, int lvl);
    return (int'(c) >= cost_of(lvl)) && (lvl < 7);
  endfunction

  // One clock; the model accrues a tick every TICK enabled clocks.
  task automatic step();
    @(posedge clk);
    if (rst_n && pins.ena) begin
      en_edges++;
      if (en_edges % TICK == 0) m_count = sat_add(m_count, m_level);
    end
    @(negedge clk);
  endtask

  task automatic steps(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic press(int b, int hi, int lo);
    pins.ui_in[b] = 1'b1;
    steps(hi);
    pins.ui_in[b] = 1'b0;
    steps(lo);
  endtask

  task automatic model_buy();
    if (m_level < 7 && int'(m_count) >= cost_of(m_level)) begin
      m_count = m_count - 16'(cost_of(m_level));
      m_level++;
    end
  endtask

  // Keep presses away from tick boundaries so model ordering is unambiguous.
  task automatic wait_phase(int lo, int hi, output bit ok);
    int n;
    n = 0;
    while (!((en_edges % TICK) >= lo && (en_edges % TICK) <= hi) && n < 300) begin
      step();
      n++;
    end
    ok = (n < 300);
  endtask

  task automatic scan_display(output bit ok);
    logic [3:0] mask;
    mask = 4'h0;
    for (int i = 0; i < 16 * MUX && mask != 4'hF; i++) begin
      step();
      case (pins.uio_out[3:0])
        4'b0001: begin seen_seg[0] = pins.uo_out[6:0]; mask[0] = 1'b1; end
        4'b0010: begin seen_seg[1] = pins.uo_out[6:0]; mask[1] = 1'b1; end
        4'b0100: begin seen_seg[2] = pins.uo_out[6:0]; mask[2] = 1'b1; end
        4'b1000: begin seen_seg[3] = pins.uo_out[6:0]; mask[3] = 1'b1; end
        default: ;
      endcase
    end
    ok = (mask == 4'hF);
  endtask

  task automatic check_display(string name, logic [15:0] val);
    bit          ok;
    logic [15:0] v;
    logic [27:0] got, exp;
    v = val;
    scan_display(ok);
    for (int d = 0; d < 4; d++) begin
      got[7*d +: 7] = seen_seg[d];
      exp[7*d +: 7] = seg_ref[v[4*d +: 4]];
    end
    tests_run++;
    if (!ok || got !== exp) begin
      fails++;
      $display("FAIL %s: scan_ok=%0d segs=%h expected %h", name, ok, got, exp);
    end
  endtask

  task automatic test_reset();
    pins.ena = 1'b1;
    pins.ui_in = 8'h00;
    pins.uio_in = 8'h00;
    rst_n = 1'b0;
    steps(3);
    tests_run++;
    if (pins.uo_out !== 8'h00 || pins.uio_out !== 8'h00 || pins.uio_oe !== 8'hFF) begin
      fails++;
      $display("FAIL reset_outputs: uo=%h uio=%h oe=%h expected 00 00 FF", pins.uo_out, pins.uio_out, pins.uio_oe);
    end
    rst_n = 1'b1;
    step();
    tests_run++;
    if (pins.uio_out !== 8'h01 || pins.uo_out !== 8'h3F) begin
      fails++;
      $display("FAIL reset_release: uio=%h uo=%h expected 01 3F", pins.uio_out, pins.uo_out);
    end
    tests_run++;
    if (dut.count !== 16'h0000) begin
      fails++;
      $display("FAIL reset_count: got %h expected 0000", dut.count);
    end
  endtask

  task automatic test_click();
    for (int i = 0; i < 5; i++) begin
      m_count = sat_add(m_count, 1);
      press(0, 10, 10);
    end
    tests_run++;
    if (dut.count !== 16'd5 || dut.count !== m_count) begin
      fails++;
      $display("FAIL click_count: got %h expected 0005 (model %h)", dut.count, m_count);
    end
    check_display("click_display", 16'h0005);
    press(0, 2, 10);
    tests_run++;
    if (dut.count !== 16'd5) begin
      fails++;
      $display("FAIL click_glitch: got %h expected 0005", dut.count);
    end
  endtask

  task automatic test_buy();
    bit ok;
    for (int i = 0; i < 10; i++) begin
      m_count = sat_add(m_count, 1);
      press(0, 10, 10);
    end
    model_buy();
    press(1, 10, 10);
    tests_run++;
    if (dut.count !== 16'd15 || pins.uio_out[6:4] !== 3'd0 || pins.uio_out[7] !== 1'b0) begin
      fails++;
      $display("FAIL buy_rejected: count=%h level=%0d afford=%b expected 000f 0 0",
               dut.count, pins.uio_out[6:4], pins.uio_out[7]);
    end
    m_count = sat_add(m_count, 1);
    press(0, 10, 10);
    tests_run++;
    if (pins.uio_out[7] !== 1'b1) begin
      fails++;
      $display("FAIL buy_affordable: got %b expected 1", pins.uio_out[7]);
    end
    wait_phase(5, 60, ok);
    model_buy();
    press(1, 10, 10);
    tests_run++;
    if (!ok || dut.count !== 16'd0 || dut.count !== m_count || pins.uio_out[6:4] !== 3'd1) begin
      fails++;
      $display("FAIL buy_accepted: count=%h level=%0d expected 0000 1", dut.count, pins.uio_out[6:4]);
    end
    pins.ui_in[7] = 1'b1;
    steps(3);
    check_display("cost_display", 16'h0020);
    pins.ui_in[7] = 1'b0;
    steps(3);
  endtask

  task automatic test_auto();
    logic [15:0] start;
    bit          dp_bad;
    bit          saw_d0;
    start = dut.count;
    dp_bad = 1'b0;
    saw_d0 = 1'b0;
    for (int i = 0; i < 300; i++) begin
      step();
      if (pins.uio_out[3:0] == 4'b0001) begin
        saw_d0 = 1'b1;
        if (pins.uo_out[7] !== 1'b1) dp_bad = 1'b1;
      end else if (pins.uo_out[7] !== 1'b0) begin
        dp_bad = 1'b1;
      end
    end
    tests_run++;
    if (dut.count - start !== 16'd3 || dut.count !== m_count) begin
      fails++;
      $display("FAIL auto_production: got %h from %h expected +3 (model %h)", dut.count, start, m_count);
    end
    tests_run++;
    if (dp_bad || !saw_d0) begin
      fails++;
      $display("FAIL auto_dp: bad=%0d seen_digit0=%0d expected 0 1", dp_bad, saw_d0);
    end
  endtask

  task automatic test_enable();
    logic [15:0] start;
    logic [3:0]  mask;
    pins.ena = 1'b0;
    start = dut.count;
    mask = 4'h0;
    for (int i = 0; i < 200; i++) begin
      pins.ui_in[0] = (i < 10);
      step();
      mask = mask | pins.uio_out[3:0];
    end
    pins.ena = 1'b1;
    tests_run++;
    if (dut.count !== start || dut.count !== m_count) begin
      fails++;
      $display("FAIL ena_gating: got %h expected %h", dut.count, start);
    end
    tests_run++;
    if (mask !== 4'hF) begin
      fails++;
      $display("FAIL ena_scan: digits seen %b expected 1111", mask);
    end
  endtask

  task automatic test_random();
    bit ok;
    int op;
    for (int n = 0; n < 40; n++) begin
      wait_phase(5, 70, ok);
      op = int'($urandom_range(0, 9));
      if (op < 7) begin
        m_count = sat_add(m_count, 1);
        press(0, int'($urandom_range(5, 12)), int'($urandom_range(7, 12)));
      end else if (op < 9) begin
        model_buy();
        press(1, int'($urandom_range(5, 12)), int'($urandom_range(7, 12)));
      end else begin
        press(int'($urandom_range(0, 1)), int'($urandom_range(1, 3)), int'($urandom_range(7, 12)));
      end
      wait_phase(5, 90, ok);
      tests_run++;
      if (!ok || dut.count !== m_count || pins.uio_out[6:4] !== 3'(m_level) ||
          pins.uio_out[7] !== afford_of(m_count, m_level)) begin
        fails++;
        $display("FAIL random_op%0d: count=%h level=%0d afford=%b expected %h %0d %b", n,
                 dut.count, pins.uio_out[6:4], pins.uio_out[7], m_count, m_level, afford_of(m_count, m_level));
      end
    end
  endtask

  task automatic test_saturation();
    bit ok;
    wait_phase(90, 90, ok);
    force dut.count = 16'hFFFE;
    force dut.level = 3'd7;
    m_count = 16'hFFFE;
    m_level = 7;
    #1;
    release dut.count;
    release dut.level;
    steps(3);
    m_count = sat_add(m_count, 1);
    press(0, 10, 10);
    tests_run++;
    if (!ok || dut.count !== 16'hFFFF || dut.count !== m_count) begin
      fails++;
      $display("FAIL saturate_click_tick: got %h expected ffff", dut.count);
    end
    model_buy();
    press(1, 10, 10);
    steps(150);
    tests_run++;
    if (dut.count !== 16'hFFFF || pins.uio_out[6:4] !== 3'd7 || pins.uio_out[7] !== 1'b0) begin
      fails++;
      $display("FAIL saturate_hold: count=%h level=%0d afford=%b expected ffff 7 0",
               dut.count, pins.uio_out[6:4], pins.uio_out[7]);
    end
    check_display("saturate_display", 16'hFFFF);
  endtask

  task automatic test_reset_mid();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (pins.uo_out !== 8'h00 || pins.uio_out !== 8'h00 || pins.uio_oe !== 8'hFF || dut.count !== 16'h0) begin
      fails++;
      $display("FAIL reset_mid: uo=%h uio=%h oe=%h count=%h expected 00 00 ff 0000",
               pins.uo_out, pins.uio_out, pins.uio_oe, dut.count);
    end
    m_count = 16'h0;
    m_level = 0;
    en_edges = 0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    tests_run++;
    if (pins.uio_out !== 8'h01 || pins.uo_out !== 8'h3F) begin
      fails++;
      $display("FAIL reset_mid_release: uio=%h uo=%h expected 01 3f", pins.uio_out, pins.uo_out);
    end
  endtask

  initial begin
    seg_ref = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    pins.ena = 1'b0;
    pins.ui_in = 8'h00;
    pins.uio_in = 8'h00;
    @(negedge clk);
    test_reset();
    test_click();
    test_buy();
    test_auto();
    test_enable();
    test_random();
    test_saturation();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
`default_nettype wire
